// File: rtl/axi_rd_arbiter_pkg.sv
// Shared AXI read-channel widths and encodings for the read arbiter slice.
// Also holds the arbiter FSM state type.
package axi_rd_arbiter_pkg;

  localparam int AXI_ID_W    = 4;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_RESP_W  = 2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/axi_rd_arbiter_rr.sv
// Round-robin picker: first requester at or after i_ptr, modulo NUM_MST.
// Doubled request vector turns the wrap-around search into a plain scan.
module rr_arbiter #(
  parameter int NUM_MST = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_MST-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_MST-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx
);

  logic [2*NUM_MST-1:0] w_dbl;
  logic [NUM_MST-1:0]   w_rot;
  logic [IDX_W:0]       w_off;
  logic [IDX_W:0]       w_sum;
  logic [IDX_W:0]       w_wrap;
  logic                 w_found;

  assign w_dbl = {i_req, i_req};
  assign w_rot = NUM_MST'(w_dbl >> i_ptr);

  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_MST; k++) begin
      if (!w_found && w_rot[k]) begin
        w_off   = (IDX_W+1)'(k);
        w_found = 1'b1;
      end
    end
  end

  assign w_sum  = {1'b0, i_ptr} + w_off;
  assign w_wrap = w_sum - (IDX_W+1)'(NUM_MST);
  assign o_idx  = (w_sum >= (IDX_W+1)'(NUM_MST))
                ? w_wrap[IDX_W-1:0] : w_sum[IDX_W-1:0];
  assign o_gnt  = w_found ? (NUM_MST'(1) << o_idx) : '0;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one single-outstanding AXI read slave among NUM_MST masters.
// Grant is registered per burst and held until the rlast handshake.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int NUM_MST = 4,
  parameter int IDX_W   = 2,
  parameter int ID_W    = AXI_ID_W,
  parameter int ADDR_W  = AXI_ADDR_W,
  parameter int LEN_W   = AXI_LEN_W,
  parameter int SIZE_W  = AXI_SIZE_W,
  parameter int BURST_W = AXI_BURST_W,
  parameter int DATA_W  = AXI_DATA_W,
  parameter int RESP_W  = AXI_RESP_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MST*ID_W-1:0]     mst_arid,
  input  logic [NUM_MST*ADDR_W-1:0]   mst_araddr,
  input  logic [NUM_MST*LEN_W-1:0]    mst_arlen,
  input  logic [NUM_MST*SIZE_W-1:0]   mst_arsize,
  input  logic [NUM_MST*BURST_W-1:0]  mst_arburst,
  input  logic [NUM_MST-1:0]          mst_arvalid,
  output logic [NUM_MST-1:0]          mst_arready,
  output logic [NUM_MST*DATA_W-1:0]   mst_rdata,
  output logic [NUM_MST*RESP_W-1:0]   mst_rresp,
  output logic [NUM_MST-1:0]          mst_rlast,
  output logic [NUM_MST-1:0]          mst_rvalid,
  input  logic [NUM_MST-1:0]          mst_rready,
  output logic [ID_W-1:0]             slv_arid,
  output logic [ADDR_W-1:0]           slv_araddr,
  output logic [LEN_W-1:0]            slv_arlen,
  output logic [SIZE_W-1:0]           slv_arsize,
  output logic [BURST_W-1:0]          slv_arburst,
  output logic                        slv_arvalid,
  input  logic                        slv_arready,
  input  logic [DATA_W-1:0]           slv_rdata,
  input  logic [RESP_W-1:0]           slv_rresp,
  input  logic                        slv_rlast,
  input  logic                        slv_rvalid,
  output logic                        slv_rready,
  output logic [IDX_W-1:0]            gnt_idx,
  output logic                        busy
);

  arb_state_e         r_state;
  arb_state_e         w_next;
  logic [IDX_W-1:0]   r_gnt;
  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_MST-1:0] w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_ar_done;
  logic               w_r_done;

  rr_arbiter #(
    .NUM_MST (NUM_MST),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req (mst_arvalid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_ar_done = (r_state == ST_ADDR) && slv_arvalid && slv_arready;
  assign w_r_done  = (r_state == ST_DATA) && slv_rvalid && slv_rready
                   && slv_rlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (|w_gnt)    w_next = ST_ADDR;
      ST_ADDR: if (w_ar_done) w_next = ST_DATA;
      ST_DATA: if (w_r_done)  w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  // Last granted master becomes lowest priority for the next burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt <= '0;
      r_ptr <= '0;
    end else begin
      if (r_state == ST_IDLE && |w_gnt) r_gnt <= w_idx;
      if (w_r_done)
        r_ptr <= (r_gnt == IDX_W'(NUM_MST-1)) ? '0 : r_gnt + 1'b1;
    end
  end

  always_comb begin
    slv_arid    = '0;
    slv_araddr  = '0;
    slv_arlen   = '0;
    slv_arsize  = '0;
    slv_arburst = '0;
    slv_arvalid = 1'b0;
    slv_rready  = 1'b0;
    mst_arready = '0;
    mst_rvalid  = '0;
    unique case (r_state)
      ST_ADDR: begin
        slv_arid           = mst_arid[r_gnt*ID_W +: ID_W];
        slv_araddr         = mst_araddr[r_gnt*ADDR_W +: ADDR_W];
        slv_arlen          = mst_arlen[r_gnt*LEN_W +: LEN_W];
        slv_arsize         = mst_arsize[r_gnt*SIZE_W +: SIZE_W];
        slv_arburst        = mst_arburst[r_gnt*BURST_W +: BURST_W];
        slv_arvalid        = mst_arvalid[r_gnt];
        mst_arready[r_gnt] = slv_arready;
      end
      ST_DATA: begin
        mst_rvalid[r_gnt] = slv_rvalid;
        slv_rready        = mst_rready[r_gnt];
      end
      default: ;
    endcase
  end

  assign mst_rdata = {NUM_MST{slv_rdata}};
  assign mst_rresp = {NUM_MST{slv_rresp}};
  assign mst_rlast = {NUM_MST{slv_rlast}};
  assign gnt_idx   = r_gnt;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: master/slave models, grant-order
// reference and per-master beat queues checked by a negedge monitor.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  len;
    logic [3:0]  id;
  } req_t;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*4-1:0]  mst_arid;
  logic [N*32-1:0] mst_araddr;
  logic [N*8-1:0]  mst_arlen;
  logic [N*3-1:0]  mst_arsize;
  logic [N*2-1:0]  mst_arburst;
  logic [N-1:0]    mst_arvalid;
  logic [N-1:0]    mst_arready;
  logic [N*32-1:0] mst_rdata;
  logic [N*2-1:0]  mst_rresp;
  logic [N-1:0]    mst_rlast;
  logic [N-1:0]    mst_rvalid;
  logic [N-1:0]    mst_rready;
  logic [3:0]      slv_arid;
  logic [31:0]     slv_araddr;
  logic [7:0]      slv_arlen;
  logic [2:0]      slv_arsize;
  logic [1:0]      slv_arburst;
  logic            slv_arvalid;
  logic            slv_arready;
  logic [31:0]     slv_rdata;
  logic [1:0]      slv_rresp;
  logic            slv_rlast;
  logic            slv_rvalid;
  logic            slv_rready;
  logic [IW-1:0]   gnt_idx;
  logic            busy;

  axi_rd_arbiter #(.NUM_MST(N), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .mst_arid(mst_arid), .mst_araddr(mst_araddr),
    .mst_arlen(mst_arlen), .mst_arsize(mst_arsize),
    .mst_arburst(mst_arburst), .mst_arvalid(mst_arvalid),
    .mst_arready(mst_arready), .mst_rdata(mst_rdata),
    .mst_rresp(mst_rresp), .mst_rlast(mst_rlast),
    .mst_rvalid(mst_rvalid), .mst_rready(mst_rready),
    .slv_arid(slv_arid), .slv_araddr(slv_araddr),
    .slv_arlen(slv_arlen), .slv_arsize(slv_arsize),
    .slv_arburst(slv_arburst), .slv_arvalid(slv_arvalid),
    .slv_arready(slv_arready), .slv_rdata(slv_rdata),
    .slv_rresp(slv_rresp), .slv_rlast(slv_rlast),
    .slv_rvalid(slv_rvalid), .slv_rready(slv_rready),
    .gnt_idx(gnt_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int    nchk = 0;
  int    nerr = 0;
  req_t  req_q[N][$];
  beat_t exp_q[N][$];
  int    gnt_q[$];
  int    order[$];
  int    rx_cnt[N];
  int    seq[N];
  int    mptr;
  bit    outst;
  bit    fast;
  bit    spur;

  bit          sl_out;
  logic [31:0] sl_a;
  logic [3:0]  sl_id;
  logic [7:0]  sl_len;
  int          sl_k;
  bit          rv;

  logic [N-1:0] s_arhs;
  bit           s_sar;
  bit           s_sr;
  logic [31:0]  c_a;
  logic [3:0]   c_id;
  logic [7:0]   c_len;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fdat(input logic [31:0] a,
                                       input logic [3:0] id, input int k);
    return (a + 32'(k * 4)) ^ {id, 28'h0};
  endfunction

  function automatic logic [1:0] fresp(input logic [3:0] id, input int k);
    return id[1:0] ^ 2'(k);
  endfunction

  // Expected beats are queued for the master the moment it issues.
  task automatic issue(input int i, input logic [31:0] a,
                       input logic [7:0] len);
    req_t  r;
    beat_t b;
    r.a   = a;
    r.len = len;
    r.id  = {2'(i), 2'(seq[i])};
    seq[i]++;
    req_q[i].push_back(r);
    for (int k = 0; k <= int'(len); k++) begin
      b.d = fdat(a, r.id, k);
      b.r = fresp(r.id, k);
      b.l = (k == int'(len));
      exp_q[i].push_back(b);
    end
  endtask

  task automatic cyc();
    req_t r;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (s_arhs[i]) mst_arvalid[i] = 1'b0;
      if (!mst_arvalid[i] && req_q[i].size() > 0) begin
        r = req_q[i].pop_front();
        mst_arvalid[i]          = 1'b1;
        mst_arid[i*4 +: 4]      = r.id;
        mst_araddr[i*32 +: 32]  = r.a;
        mst_arlen[i*8 +: 8]     = r.len;
        mst_arsize[i*3 +: 3]    = 3'(i);
        mst_arburst[i*2 +: 2]   = AXI_BURST_INCR;
      end
      mst_rready[i] = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    if (s_sr) begin
      rv = 1'b0;
      if (sl_out) begin
        if (sl_k == int'(sl_len)) sl_out = 1'b0;
        else sl_k++;
      end
    end
    if (s_sar) begin
      sl_out = 1'b1;
      sl_a   = c_a;
      sl_id  = c_id;
      sl_len = c_len;
      sl_k   = 0;
      rv     = 1'b0;
    end
    if (sl_out && !rv) rv = fast || ($urandom_range(0, 2) != 0);
    slv_rvalid  = rv || (spur && !sl_out);
    slv_rdata   = fdat(sl_a, sl_id, sl_k);
    slv_rresp   = fresp(sl_id, sl_k);
    slv_rlast   = sl_out ? (sl_k == int'(sl_len)) : 1'b1;
    slv_arready = !sl_out && (fast || $urandom_range(0, 1) == 1);
    @(negedge clk);
    s_arhs = mst_arvalid & mst_arready;
    s_sar  = slv_arvalid && slv_arready;
    s_sr   = slv_rvalid && slv_rready;
    c_a    = slv_araddr;
    c_id   = slv_arid;
    c_len  = slv_arlen;
    #2;
  endtask

  function automatic bit quiet();
    bit q;
    q = !busy && !sl_out && (mst_arvalid == '0) && (gnt_q.size() == 0);
    for (int i = 0; i < N; i++)
      if (req_q[i].size() != 0 || exp_q[i].size() != 0) q = 1'b0;
    return q;
  endfunction

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (!quiet() && t < 2000) begin
      cyc();
      t++;
    end
    chk(nm, 64'(quiet()), 64'd1);
  endtask

  task automatic clear_tb();
    for (int i = 0; i < N; i++) begin
      req_q[i].delete();
      exp_q[i].delete();
    end
    mst_arvalid = '0;
    mst_rready  = '0;
    sl_out      = 1'b0;
    rv          = 1'b0;
    sl_k        = 0;
    sl_len      = '0;
    s_arhs      = '0;
    s_sar       = 1'b0;
    s_sr        = 1'b0;
    slv_rvalid  = 1'b0;
    slv_arready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_tb();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [48:0] p_fields;
  bit          p_hold;
  int          e;
  int          w;
  int          m;
  beat_t       b;

  always @(negedge clk) begin
    if (rst) begin
      gnt_q.delete();
      mptr   = 0;
      outst  = 1'b0;
      p_hold = 1'b0;
    end else begin
      if (!busy)
        chk("idle_quiet", 64'({slv_arvalid, slv_rready, mst_arready,
                                mst_rvalid}), 64'd0);
      chk("arready_gnt", 64'(mst_arready & ~(N'(1) << gnt_idx)), 64'd0);
      chk("rvalid_gnt", 64'(mst_rvalid & ~(N'(1) << gnt_idx)), 64'd0);
      chk("rready_in_addr", 64'(slv_arvalid && slv_rready), 64'd0);
      if (p_hold && slv_arvalid)
        chk("ar_stable", 64'({slv_arid, slv_araddr, slv_arlen, slv_arsize,
                              slv_arburst}), 64'(p_fields));
      p_hold   = slv_arvalid && !slv_arready;
      p_fields = {slv_arid, slv_araddr, slv_arlen, slv_arsize, slv_arburst};
      if (slv_arvalid && slv_arready) begin
        chk("ar_single_outst", 64'(outst), 64'd0);
        outst = 1'b1;
        order.push_back(int'(slv_arid[3:2]));
        chk("gnt_q_nonempty", 64'(gnt_q.size() != 0), 64'd1);
        if (gnt_q.size() != 0) begin
          e = gnt_q.pop_front();
          chk("gnt_master", 64'(slv_arid[3:2]), 64'(e));
          chk("gnt_idx", 64'(gnt_idx), 64'(e));
        end
      end
      if (slv_rvalid && slv_rready && slv_rlast) outst = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (mst_rvalid[i] && mst_rready[i]) begin
          rx_cnt[i]++;
          chk("rx_expected", 64'(exp_q[i].size() != 0), 64'd1);
          if (exp_q[i].size() != 0) begin
            b = exp_q[i].pop_front();
            chk("rx_beat", 64'({mst_rdata[i*32 +: 32], mst_rresp[i*2 +: 2],
                                mst_rlast[i]}), 64'({b.d, b.r, b.l}));
          end
        end
      end
      // Reference: next grant is first requester at/after last winner + 1.
      if (!busy && mst_arvalid != '0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          m = (mptr + k) % N;
          if (w < 0 && mst_arvalid[m]) w = m;
        end
        gnt_q.push_back(w);
        mptr = (w + 1) % N;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int exp_o[5] = '{0, 1, 2, 3, 0};
  int b0;
  int b1;
  int b2;
  int t;

  initial begin
    rst         = 1'b1;
    mst_arid    = '0;
    mst_araddr  = '0;
    mst_arlen   = '0;
    mst_arsize  = '0;
    mst_arburst = '0;
    slv_rdata   = '0;
    slv_rresp   = '0;
    slv_rlast   = 1'b0;
    fast        = 1'b0;
    spur        = 1'b0;
    sl_a        = '0;
    sl_id       = '0;
    c_a         = '0;
    c_id        = '0;
    c_len       = '0;
    for (int i = 0; i < N; i++) begin
      rx_cnt[i] = 0;
      seq[i]    = 0;
    end
    clear_tb();
    repeat (2) @(posedge clk);
    #1;
    mst_arvalid = '1;
    #1;
    chk("rst_ctrl", 64'({busy, gnt_idx, slv_arvalid, slv_rready,
                         mst_arready, mst_rvalid}), 64'd0);
    chk("rst_ar_fields", 64'({slv_arid, slv_araddr, slv_arlen}), 64'd0);
    mst_arvalid = '0;
    do_reset();

    // Single request from master 2.
    b0 = rx_cnt[0]; b1 = rx_cnt[1]; b2 = rx_cnt[2];
    t  = rx_cnt[3];
    issue(2, 32'h40, 8'd3);
    cyc();
    chk("t1_idle_cycle", 64'({busy, slv_arvalid}), 64'd0);
    cyc();
    chk("t1_arvalid", 64'(slv_arvalid), 64'd1);
    chk("t1_gnt", 64'(gnt_idx), 64'd2);
    chk("t1_addr", 64'(slv_araddr), 64'h40);
    wait_idle("t1_drain");
    chk("t1_beats_m2", 64'(rx_cnt[2] - b2), 64'd4);
    chk("t1_beats_other", 64'((rx_cnt[0] - b0) + (rx_cnt[1] - b1) +
                              (rx_cnt[3] - t)), 64'd0);

    // All four at once from pointer 0, master 0 twice.
    do_reset();
    fast = 1'b1;
    order.delete();
    issue(0, 32'h1000, 8'd1);
    issue(0, 32'h2000, 8'd2);
    issue(1, 32'h1100, 8'd3);
    issue(2, 32'h1200, 8'd0);
    issue(3, 32'h1300, 8'd2);
    wait_idle("t2_drain");
    chk("t2_order_len", 64'(order.size()), 64'd5);
    for (int j = 0; j < 5 && j < order.size(); j++)
      chk("t2_order", 64'(order[j]), 64'(exp_o[j]));

    // Late request lands in the rlast cycle of master 0.
    issue(0, 32'h3000, 8'd0);
    t = 0;
    while (!s_sar && t < 50) begin
      cyc();
      t++;
    end
    chk("t6_ar_seen", 64'(s_sar), 64'd1);
    issue(3, 32'h3300, 8'd1);
    cyc();
    cyc();
    chk("t6_bubble", 64'(busy), 64'd0);
    cyc();
    chk("t6_gnt3", 64'({gnt_idx, slv_arvalid}), 64'({2'd3, 1'b1}));
    wait_idle("t6_drain");

    // Reset after beat 2 of an 8-beat burst.
    b0 = rx_cnt[0];
    issue(0, 32'h4000, 8'd7);
    t = 0;
    while (rx_cnt[0] - b0 < 2 && t < 100) begin
      cyc();
      t++;
    end
    chk("t5_two_beats", 64'(rx_cnt[0] - b0), 64'd2);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_ctrl", 64'({busy, gnt_idx, slv_arvalid, slv_rready,
                            mst_arready, mst_rvalid}), 64'd0);
    chk("t5_rst_fields", 64'({slv_arid, slv_araddr, slv_arlen}), 64'd0);
    do_reset();
    fast = 1'b0;
    spur = 1'b1;
    b1 = rx_cnt[1];
    issue(1, 32'h5100, 8'd2);
    wait_idle("t5_m1_drain");
    chk("t5_m1_beats", 64'(rx_cnt[1] - b1), 64'd3);
    spur = 1'b0;

    // Random traffic with random AR/R backpressure.
    repeat (3000) begin
      for (int i = 0; i < N; i++)
        if (req_q[i].size() < 2 && $urandom_range(0, 9) == 0)
          issue(i, $urandom() & 32'hFFFF_FFF0, 8'($urandom_range(0, 7)));
      cyc();
    end
    wait_idle("rand_drain");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
